issue_grad_rob: RTL and testbench
=================================

Name: issue_grad_rob

Overview:
- Parametrised successor to the single-in-flight issue/graduation unit.
- Allows up to DEPTH instructions in flight across NUM_FU functional units, with RAW scoreboarding on issue.
- Functional units complete out of order by tag; instructions graduate in order from a circular completion queue.
- Redirects, replays and exceptions are taken precisely at the queue head. Sits between decode and the register file / fetch.

Parameters:
DEPTH, 4, completion-queue entries (power of 2, 2..16)
NUM_FU, 7, number of functional units (one-hot funit select)
TAG_W, $clog2(DEPTH), tag width
RESET_ADDR, 64'h0, fetch address after reset
EXC_ADDR, 64'h100, exception vector

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
id_vld  in  1  decode presents an instruction
id_pc  in  64  instruction PC
id_funit  in  NUM_FU  one-hot target unit (all-zero = no unit: exception/hw_ret)
id_rdst  in  5  destination register
id_rsrc_a  in  5  source register A
id_rsrc_b  in  5  source register B
id_no_rf_upd  in  1  no RF write
id_exc  in  3  {halt, reserved, callpal}
id_hw_ret  in  1  exception return
id_issue  out  1  instruction accepted this cycle
funit_en_e0  out  NUM_FU  registered unit enable
tag_e0  out  TAG_W  registered tag for the enabled unit
fu_busy  in  NUM_FU  unit has work outstanding
fu_done  in  NUM_FU  per-unit completion strobe
fu_tag  in  NUM_FU*TAG_W  completion tags
fu_data  in  NUM_FU*64  results
fu_wen_ok  in  NUM_FU  conditional-write enable (1 = write)
fu_redir  in  NUM_FU  completion requests redirect
fu_replay  in  NUM_FU  completion requests replay
fu_tgt  in  NUM_FU*64  redirect target
rf_wen_gr  out  1  RF write enable
rf_waddr_gr  out  5  RF write address
rf_wdata_gr  out  64  RF write data
grad_gr  out  1  head graduated
redir_vld_xx  out  1  fetch redirect
redir_addr_xx  out  64  redirect address
e_enter_gr  out  1  exception taken
e_exit_gr  out  1  hw_ret graduated
n_epc_gr  out  64  faulting PC
n_cause_gr  out  3  cause {halt, reserved, callpal}
halted  out  1  sticky halt

Behaviour:

Reset and output defaults:
- During reset: queue empty (head = tail = 0, count = 0), state RUN, halted = 0, funit_en_e0 = 0.
- All pulse outputs are 0 during reset.
- Post-reset: in the first cycle after reset deasserts, redir_vld_xx = 1 with redir_addr_xx = RESET_ADDR; id_issue is 0 that cycle.

Entry format:
- Fields: valid, done, pc, rdst, no_rf_upd, exc[2:0], hw_ret, data[63:0], wen_ok, redir, replay, tgt.

Issue:
- Condition: id_issue = id_vld & state==RUN & count<DEPTH & ~halted & ~raw & ~post_reset & ~flush_now.
- raw = any valid entry that writes an RF register (~no_rf_upd, rdst!=31) with rdst equal to a non-31 id_rsrc_a or id_rsrc_b.
- Full blocks issue even if the head graduates in the same cycle.
- On issue: write the entry at tail; tail increments modulo DEPTH with wrap.
- Next cycle: funit_en_e0 = id_funit and tag_e0 = the old tail.
- id_funit == 0 (exception/hw_ret): the entry is marked done at issue.

Completion:
- For each i with fu_done[i], set done and capture data, wen_ok, redir, replay and tgt into the entry at fu_tag[i].
- Multiple units may complete the same cycle with distinct tags.
- A completion to a non-valid tag, or any completion in DRAIN, is ignored.

Graduation (head valid & done), priority order:
1. replay: no graduation; redirect to the entry pc; flush.
2. exc != 0:
   - halt: grad_gr = 1, halted := 1, no redirect, state HALT.
   - otherwise: e_enter_gr = 1, n_epc_gr = pc, n_cause_gr = exc, redirect to EXC_ADDR, flush.
3. Normal:
   - grad_gr = 1.
   - rf_wen_gr = ~no_rf_upd & wen_ok & rdst!=31; rf_waddr_gr / rf_wdata_gr come from the entry.
   - e_exit_gr = hw_ret.
   - If redir: redirect to tgt and flush.
- At most one graduation per cycle; graduation is combinational from queue state.

Flush:
- Clears all entries, sets count = 0, head = tail, funit_en_e0 = 0.
- Next state is DRAIN if any fu_busy, else RUN.
- A same-cycle issue is suppressed.

States:
- RUN: normal operation.
- DRAIN: issue blocked and completions dropped until fu_busy == 0, then RUN.
- HALT: absorbing until reset; no issue, completions accepted, no further graduation.

Simultaneous events:
- Issue, completions and a non-flushing graduation may all occur in one cycle.
- count updates by +issue − grad.

Reset mid-operation:
- Overrides every state; queue contents are discarded.

Test Plan:
1. Reset release -> exactly one cycle of redir_vld_xx = 1 with addr = RESET_ADDR; no issue that cycle.
2. Four independent adds issued back to back with DEPTH = 4; completions return in tag order 3, 1, 0, 2 -> grad_gr pulses in program order 0, 1, 2, 3 with the matching rf_waddr/rf_wdata; a fifth id_vld is stalled until the first graduation.
3. Write r5, then an instruction reading r5 -> second id_issue held 0 until the first graduates; a source of r31 never stalls.
4. Branch at tag 1 completes with redir and tgt = 0x2000 while tag 2 is in flight and fu_busy is held 3 cycles -> redir_addr_xx = 0x2000, tag 2 result dropped, issue resumes only after fu_busy == 0.
5. Reserved-opcode entry at head behind a completed add -> the add graduates, then e_enter_gr = 1, n_epc_gr = its pc, n_cause_gr = 3'b010, redirect to EXC_ADDR.
6. LSU replay at head with pc 0x1040 -> no grad_gr, redirect to 0x1040; halt at head -> halted = 1 sticky, id_issue stays 0 until reset.

Source files
------------

// File: rtl/issue_grad_rob.sv
// issue_grad_rob
//   Issue / in-order graduation unit with a circular completion queue.
//   Up to DEPTH instructions may be in flight across NUM_FU functional
//   units. Issue is blocked on RAW hazards against in-flight writers.
//   Units complete out of order by tag, and the head graduates in order.
//   Redirects, replays and exceptions are taken precisely at the head.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   id_*                            decoded instruction from decode
//   id_issue                        instruction accepted this cycle
//   funit_en_e0, tag_e0             registered unit enable and tag
//   fu_busy, fu_done, fu_tag,
//   fu_data, fu_wen_ok, fu_redir,
//   fu_replay, fu_tgt               per-unit completion interface
//   rf_wen_gr, rf_waddr_gr,
//   rf_wdata_gr                     register-file write port
//   grad_gr                         head graduated
//   redir_vld_xx, redir_addr_xx     fetch redirect
//   e_enter_gr, e_exit_gr,
//   n_epc_gr, n_cause_gr            exception entry/exit
//   halted                          sticky halt indication
module issue_grad_rob #(
  parameter int          DEPTH      = 4,
  parameter int          NUM_FU     = 7,
  parameter int          TAG_W      = $clog2(DEPTH),
  parameter logic [63:0] RESET_ADDR = 64'h0,
  parameter logic [63:0] EXC_ADDR   = 64'h100
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_vld,
  input  logic [63:0]          id_pc,
  input  logic [NUM_FU-1:0]    id_funit,
  input  logic [4:0]           id_rdst,
  input  logic [4:0]           id_rsrc_a,
  input  logic [4:0]           id_rsrc_b,
  input  logic                 id_no_rf_upd,
  input  logic [2:0]           id_exc,
  input  logic                 id_hw_ret,
  output logic                 id_issue,
  output logic [NUM_FU-1:0]    funit_en_e0,
  output logic [TAG_W-1:0]     tag_e0,
  input  logic [NUM_FU-1:0]    fu_busy,
  input  logic [NUM_FU-1:0]    fu_done,
  input  logic [NUM_FU*TAG_W-1:0] fu_tag,
  input  logic [NUM_FU*64-1:0] fu_data,
  input  logic [NUM_FU-1:0]    fu_wen_ok,
  input  logic [NUM_FU-1:0]    fu_redir,
  input  logic [NUM_FU-1:0]    fu_replay,
  input  logic [NUM_FU*64-1:0] fu_tgt,
  output logic                 rf_wen_gr,
  output logic [4:0]           rf_waddr_gr,
  output logic [63:0]          rf_wdata_gr,
  output logic                 grad_gr,
  output logic                 redir_vld_xx,
  output logic [63:0]          redir_addr_xx,
  output logic                 e_enter_gr,
  output logic                 e_exit_gr,
  output logic [63:0]          n_epc_gr,
  output logic [2:0]           n_cause_gr,
  output logic                 halted
);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  state_t           state;
  logic [TAG_W-1:0] head, tail;
  logic [TAG_W:0]   count;
  logic             post_reset;

  logic [DEPTH-1:0] e_valid, e_done, e_no_rf_upd, e_hw_ret;
  logic [DEPTH-1:0] e_wen_ok, e_redir, e_replay;
  logic [63:0]      e_pc   [DEPTH];
  logic [4:0]       e_rdst [DEPTH];
  logic [2:0]       e_exc  [DEPTH];
  logic [63:0]      e_data [DEPTH];
  logic [63:0]      e_tgt  [DEPTH];

  logic [TAG_W-1:0] cpl_tag [NUM_FU];
  logic             raw, head_ok, halt_grad, flush_now;

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) cpl_tag[i] = fu_tag[i*TAG_W +: TAG_W];
  end

  // r31 is the zero register: neither a writer of r31 nor a reader of r31
  // creates a dependence.
  always_comb begin
    raw = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (e_valid[i] && !e_no_rf_upd[i] && e_rdst[i] != 5'd31 &&
          ((id_rsrc_a != 5'd31 && id_rsrc_a == e_rdst[i]) ||
           (id_rsrc_b != 5'd31 && id_rsrc_b == e_rdst[i])))
        raw = 1'b1;
    end
  end

  // Head decision. Replay beats exceptions, which beat a normal graduation;
  // a halting entry graduates but does not redirect.
  always_comb begin
    grad_gr       = 1'b0;
    rf_wen_gr     = 1'b0;
    e_enter_gr    = 1'b0;
    e_exit_gr     = 1'b0;
    halt_grad     = 1'b0;
    flush_now     = 1'b0;
    redir_vld_xx  = 1'b0;
    redir_addr_xx = '0;
    rf_waddr_gr   = e_rdst[head];
    rf_wdata_gr   = e_data[head];
    n_epc_gr      = e_pc[head];
    n_cause_gr    = e_exc[head];
    head_ok = !reset && !post_reset && state == RUN && e_valid[head] && e_done[head];
    if (!reset && post_reset) begin
      redir_vld_xx  = 1'b1;
      redir_addr_xx = RESET_ADDR;
    end else if (head_ok) begin
      if (e_replay[head]) begin
        flush_now     = 1'b1;
        redir_vld_xx  = 1'b1;
        redir_addr_xx = e_pc[head];
      end else if (e_exc[head] != 3'b000) begin
        if (e_exc[head][2]) begin
          grad_gr   = 1'b1;
          halt_grad = 1'b1;
        end else begin
          e_enter_gr    = 1'b1;
          flush_now     = 1'b1;
          redir_vld_xx  = 1'b1;
          redir_addr_xx = EXC_ADDR;
        end
      end else begin
        grad_gr   = 1'b1;
        rf_wen_gr = !e_no_rf_upd[head] && e_wen_ok[head] && e_rdst[head] != 5'd31;
        e_exit_gr = e_hw_ret[head];
        if (e_redir[head]) begin
          flush_now     = 1'b1;
          redir_vld_xx  = 1'b1;
          redir_addr_xx = e_tgt[head];
        end
      end
    end
  end

  // Full blocks issue even when the head pops this cycle, which keeps the
  // issue path independent of graduation timing.
  assign id_issue = id_vld && !reset && state == RUN && count < FULL_CNT &&
                    !halted && !raw && !post_reset && !flush_now;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      halted      <= 1'b0;
      post_reset  <= 1'b1;
      funit_en_e0 <= '0;
      tag_e0      <= '0;
      e_valid     <= '0;
      e_done      <= '0;
    end else begin
      post_reset <= 1'b0;
      if (flush_now) begin
        e_valid     <= '0;
        e_done      <= '0;
        head        <= tail;
        count       <= '0;
        funit_en_e0 <= '0;
        state       <= (fu_busy != '0) ? DRAIN : RUN;
      end else begin
        funit_en_e0 <= id_issue ? id_funit : '0;
        count <= count + {{TAG_W{1'b0}}, id_issue} - {{TAG_W{1'b0}}, grad_gr};
        if (state == DRAIN && fu_busy == '0) state <= RUN;
        if (halt_grad) begin
          state  <= HALT;
          halted <= 1'b1;
        end
        // Completions to entries that are not in flight are dropped, as are
        // all completions while draining a flushed window.
        if (state != DRAIN) begin
          for (int i = 0; i < NUM_FU; i++) begin
            if (fu_done[i] && e_valid[cpl_tag[i]]) begin
              e_done[cpl_tag[i]]   <= 1'b1;
              e_data[cpl_tag[i]]   <= fu_data[i*64 +: 64];
              e_wen_ok[cpl_tag[i]] <= fu_wen_ok[i];
              e_redir[cpl_tag[i]]  <= fu_redir[i];
              e_replay[cpl_tag[i]] <= fu_replay[i];
              e_tgt[cpl_tag[i]]    <= fu_tgt[i*64 +: 64];
            end
          end
        end
        if (grad_gr) begin
          e_valid[head] <= 1'b0;
          e_done[head]  <= 1'b0;
          head          <= head + TAG_W'(1);
        end
        // Entries with no unit (exception / hw_ret) need no completion.
        if (id_issue) begin
          tag_e0            <= tail;
          e_valid[tail]     <= 1'b1;
          e_done[tail]      <= (id_funit == '0);
          e_pc[tail]        <= id_pc;
          e_rdst[tail]      <= id_rdst;
          e_no_rf_upd[tail] <= id_no_rf_upd;
          e_exc[tail]       <= id_exc;
          e_hw_ret[tail]    <= id_hw_ret;
          e_wen_ok[tail]    <= 1'b0;
          e_redir[tail]     <= 1'b0;
          e_replay[tail]    <= 1'b0;
          tail              <= tail + TAG_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_issue_grad_rob.sv
// tb_issue_grad_rob
//   Directed bench for issue_grad_rob (DEPTH 4, 7 units). Each cycle the
//   inputs are driven just after the rising edge, outputs are compared a
//   little later in the same cycle, and then the clock advances.
module tb_issue_grad_rob;

  localparam int          DEPTH      = 4;
  localparam int          NUM_FU     = 7;
  localparam int          TAG_W      = 2;
  localparam logic [63:0] RESET_ADDR = 64'h0;
  localparam logic [63:0] EXC_ADDR   = 64'h100;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    id_vld;
  logic [63:0]             id_pc;
  logic [NUM_FU-1:0]       id_funit;
  logic [4:0]              id_rdst, id_rsrc_a, id_rsrc_b;
  logic                    id_no_rf_upd;
  logic [2:0]              id_exc;
  logic                    id_hw_ret;
  logic                    id_issue;
  logic [NUM_FU-1:0]       funit_en_e0;
  logic [TAG_W-1:0]        tag_e0;
  logic [NUM_FU-1:0]       fu_busy, fu_done, fu_wen_ok, fu_redir, fu_replay;
  logic [NUM_FU*TAG_W-1:0] fu_tag;
  logic [NUM_FU*64-1:0]    fu_data, fu_tgt;
  logic                    rf_wen_gr;
  logic [4:0]              rf_waddr_gr;
  logic [63:0]             rf_wdata_gr;
  logic                    grad_gr, redir_vld_xx;
  logic [63:0]             redir_addr_xx;
  logic                    e_enter_gr, e_exit_gr;
  logic [63:0]             n_epc_gr;
  logic [2:0]              n_cause_gr;
  logic                    halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  issue_grad_rob #(
    .DEPTH(DEPTH), .NUM_FU(NUM_FU), .TAG_W(TAG_W),
    .RESET_ADDR(RESET_ADDR), .EXC_ADDR(EXC_ADDR)
  ) dut (
    .clk(clk), .reset(reset),
    .id_vld(id_vld), .id_pc(id_pc), .id_funit(id_funit), .id_rdst(id_rdst),
    .id_rsrc_a(id_rsrc_a), .id_rsrc_b(id_rsrc_b), .id_no_rf_upd(id_no_rf_upd),
    .id_exc(id_exc), .id_hw_ret(id_hw_ret), .id_issue(id_issue),
    .funit_en_e0(funit_en_e0), .tag_e0(tag_e0),
    .fu_busy(fu_busy), .fu_done(fu_done), .fu_tag(fu_tag), .fu_data(fu_data),
    .fu_wen_ok(fu_wen_ok), .fu_redir(fu_redir), .fu_replay(fu_replay), .fu_tgt(fu_tgt),
    .rf_wen_gr(rf_wen_gr), .rf_waddr_gr(rf_waddr_gr), .rf_wdata_gr(rf_wdata_gr),
    .grad_gr(grad_gr), .redir_vld_xx(redir_vld_xx), .redir_addr_xx(redir_addr_xx),
    .e_enter_gr(e_enter_gr), .e_exit_gr(e_exit_gr), .n_epc_gr(n_epc_gr),
    .n_cause_gr(n_cause_gr), .halted(halted)
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic apply_stimulus(input logic vld, input logic [63:0] pc, input logic [NUM_FU-1:0] funit,
                                input logic [4:0] rdst, input logic [4:0] ra, input logic [4:0] rb,
                                input logic no_rf, input logic [2:0] exc, input logic hw_ret);
    id_vld = vld; id_pc = pc; id_funit = funit; id_rdst = rdst;
    id_rsrc_a = ra; id_rsrc_b = rb; id_no_rf_upd = no_rf; id_exc = exc; id_hw_ret = hw_ret;
  endtask

  task automatic no_instr();
    apply_stimulus(1'b0, 64'h0, '0, 5'd0, 5'd31, 5'd31, 1'b1, 3'b000, 1'b0);
  endtask

  task automatic complete(input int u, input logic [TAG_W-1:0] tag, input logic [63:0] data,
                          input logic wen, input logic redir, input logic replay, input logic [63:0] tgt);
    fu_done[u] = 1'b1;
    fu_tag[u*TAG_W +: TAG_W] = tag;
    fu_data[u*64 +: 64] = data;
    fu_wen_ok[u] = wen;
    fu_redir[u] = redir;
    fu_replay[u] = replay;
    fu_tgt[u*64 +: 64] = tgt;
  endtask

  task automatic clear_cpl();
    fu_done = '0; fu_tag = '0; fu_data = '0; fu_wen_ok = '0;
    fu_redir = '0; fu_replay = '0; fu_tgt = '0;
  endtask

  // Check one graduation with its register-file write.
  task automatic check_grad(input string tag, input logic wen, input logic [4:0] addr, input logic [63:0] data);
    check_output({tag, "_grad"}, grad_gr, 1'b1);
    check_output({tag, "_wen"}, rf_wen_gr, wen);
    if (wen) begin
      check_output({tag, "_waddr"}, rf_waddr_gr, addr);
      check_output({tag, "_wdata"}, rf_wdata_gr, data);
    end
  endtask

  initial begin
    reset = 1'b1;
    fu_busy = '0;
    no_instr();
    clear_cpl();

    // Reset: outputs quiet
    repeat (3) tick();
    settle();
    check_output("rst_redir", redir_vld_xx, 1'b0);
    check_output("rst_funit_en", funit_en_e0, '0);
    check_output("rst_halted", halted, 1'b0);
    check_output("rst_grad", grad_gr, 1'b0);

    // Post-reset cycle: reset redirect, no issue
    reset = 1'b0;
    apply_stimulus(1'b1, 64'h1000, 7'h01, 5'd1, 5'd31, 5'd31, 1'b0, 3'b000, 1'b0);
    settle();
    check_output("post_redir_vld", redir_vld_xx, 1'b1);
    check_output("post_redir_addr", redir_addr_xx, RESET_ADDR);
    check_output("post_issue", id_issue, 1'b0);
    tick();

    // Four independent adds, tags 0..3
    settle();
    check_output("post_redir_gone", redir_vld_xx, 1'b0);
    check_output("i0_issue", id_issue, 1'b1);
    tick();
    apply_stimulus(1'b1, 64'h1004, 7'h01, 5'd2, 5'd31, 5'd31, 1'b0, 3'b000, 1'b0);
    settle();
    check_output("i0_funit_en", funit_en_e0, 7'h01);
    check_output("i0_tag", tag_e0, 2'd0);
    check_output("i1_issue", id_issue, 1'b1);
    tick();
    apply_stimulus(1'b1, 64'h1008, 7'h01, 5'd3, 5'd31, 5'd31, 1'b0, 3'b000, 1'b0);
    settle();
    check_output("i1_tag", tag_e0, 2'd1);
    check_output("i2_issue", id_issue, 1'b1);
    tick();
    apply_stimulus(1'b1, 64'h100C, 7'h01, 5'd4, 5'd31, 5'd31, 1'b0, 3'b000, 1'b0);
    settle();
    check_output("i2_tag", tag_e0, 2'd2);
    check_output("i3_issue", id_issue, 1'b1);
    tick();

    // Queue full: fifth instruction stalls; completions arrive 3,1,0,2
    apply_stimulus(1'b1, 64'h1010, 7'h01, 5'd6, 5'd31, 5'd31, 1'b0, 3'b000, 1'b0);
    complete(0, 2'd3, 64'hD3, 1'b1, 1'b0, 1'b0, 64'h0);
    settle();
    check_output("i3_tag", tag_e0, 2'd3);
    check_output("full_issue_a", id_issue, 1'b0);
    tick();
    clear_cpl();
    complete(1, 2'd1, 64'hD1, 1'b1, 1'b0, 1'b0, 64'h0);
    settle();
    check_output("full_funit_en", funit_en_e0, '0);
    check_output("full_issue_b", id_issue, 1'b0);
    check_output("no_grad_a", grad_gr, 1'b0);
    tick();
    clear_cpl();
    complete(2, 2'd0, 64'hD0, 1'b1, 1'b0, 1'b0, 64'h0);
    settle();
    check_output("no_grad_b", grad_gr, 1'b0);
    tick();
    clear_cpl();
    complete(0, 2'd2, 64'hD2, 1'b1, 1'b0, 1'b0, 64'h0);
    settle();
    check_grad("g0", 1'b1, 5'd1, 64'hD0);
    check_output("full_while_grad", id_issue, 1'b0);
    tick();
    clear_cpl();
    settle();
    check_grad("g1", 1'b1, 5'd2, 64'hD1);
    check_output("i4_issue", id_issue, 1'b1);
    tick();
    no_instr();
    settle();
    check_grad("g2", 1'b1, 5'd3, 64'hD2);
    check_output("i4_tag", tag_e0, 2'd0);
    tick();
    settle();
    check_grad("g3", 1'b1, 5'd4, 64'hD3);
    tick();
    settle();
    check_output("i4_not_done", grad_gr, 1'b0);

    // RAW: write r5 then read r5
    complete(3, 2'd0, 64'h66, 1'b1, 1'b0, 1'b0, 64'h0);
    apply_stimulus(1'b1, 64'h1014, 7'h01, 5'd5, 5'd31, 5'd31, 1'b0, 3'b000, 1'b0);
    settle();
    check_output("i5_issue", id_issue, 1'b1);
    tick();
    clear_cpl();
    apply_stimulus(1'b1, 64'h1018, 7'h01, 5'd7, 5'd5, 5'd31, 1'b0, 3'b000, 1'b0);
    settle();
    check_grad("g4", 1'b1, 5'd6, 64'h66);
    check_output("raw_stall_a", id_issue, 1'b0);
    tick();
    complete(0, 2'd1, 64'h55, 1'b1, 1'b0, 1'b0, 64'h0);
    settle();
    check_output("raw_stall_b", id_issue, 1'b0);
    tick();
    clear_cpl();
    settle();
    check_grad("g5", 1'b1, 5'd5, 64'h55);
    check_output("raw_stall_grad", id_issue, 1'b0);
    tick();
    settle();
    check_output("raw_release", id_issue, 1'b1);
    tick();
    // A writer of r31 followed by a reader of r31 never stalls
    apply_stimulus(1'b1, 64'h101C, 7'h02, 5'd31, 5'd8, 5'd9, 1'b0, 3'b000, 1'b0);
    settle();
    check_output("i7_issue", id_issue, 1'b1);
    tick();
    apply_stimulus(1'b1, 64'h1020, 7'h01, 5'd10, 5'd31, 5'd31, 1'b0, 3'b000, 1'b0);
    settle();
    check_output("r31_no_stall", id_issue, 1'b1);
    tick();
    no_instr();
    // Three completions in one cycle
    complete(0, 2'd2, 64'h77, 1'b1, 1'b0, 1'b0, 64'h0);
    complete(1, 2'd3, 64'hFF, 1'b1, 1'b0, 1'b0, 64'h0);
    complete(2, 2'd0, 64'hAA, 1'b1, 1'b0, 1'b0, 64'h0);
    tick();
    clear_cpl();
    settle();
    check_grad("g6", 1'b1, 5'd7, 64'h77);
    tick();
    settle();
    check_grad("g7_r31", 1'b0, 5'd31, 64'hFF);
    tick();
    settle();
    check_grad("g8", 1'b1, 5'd10, 64'hAA);
    tick();
    settle();
    check_output("empty_grad", grad_gr, 1'b0);

    // Branch redirect with a younger op in flight and a busy unit
    apply_stimulus(1'b1, 64'h1100, 7'h08, 5'd31, 5'd31, 5'd31, 1'b1, 3'b000, 1'b0);
    settle();
    check_output("b0_issue", id_issue, 1'b1);
    tick();
    apply_stimulus(1'b1, 64'h1104, 7'h10, 5'd11, 5'd31, 5'd31, 1'b0, 3'b000, 1'b0);
    settle();
    check_output("b1_issue", id_issue, 1'b1);
    tick();
    no_instr();
    complete(3, 2'd1, 64'h0, 1'b0, 1'b1, 1'b0, 64'h2000);
    fu_busy = 7'h10;
    tick();
    clear_cpl();
    apply_stimulus(1'b1, 64'h2000, 7'h01, 5'd12, 5'd31, 5'd31, 1'b0, 3'b000, 1'b0);
    settle();
    check_output("br_grad", grad_gr, 1'b1);
    check_output("br_wen", rf_wen_gr, 1'b0);
    check_output("br_redir_vld", redir_vld_xx, 1'b1);
    check_output("br_redir_addr", redir_addr_xx, 64'h2000);
    check_output("br_issue_blocked", id_issue, 1'b0);
    tick();
    complete(4, 2'd2, 64'hBAD, 1'b1, 1'b0, 1'b0, 64'h0);
    settle();
    check_output("drain_funit_en", funit_en_e0, '0);
    check_output("drain_issue_a", id_issue, 1'b0);
    tick();
    clear_cpl();
    settle();
    check_output("drain_issue_b", id_issue, 1'b0);
    check_output("drain_dropped", grad_gr, 1'b0);
    tick();
    fu_busy = '0;
    settle();
    check_output("drain_issue_c", id_issue, 1'b0);
    tick();
    settle();
    check_output("c0_issue", id_issue, 1'b1);
    tick();

    // Reserved opcode behind a completed add
    apply_stimulus(1'b1, 64'h2004, 7'h00, 5'd31, 5'd31, 5'd31, 1'b1, 3'b010, 1'b0);
    complete(0, 2'd3, 64'hC0, 1'b1, 1'b0, 1'b0, 64'h0);
    settle();
    check_output("c0_funit_en", funit_en_e0, 7'h01);
    check_output("c0_tag", tag_e0, 2'd3);
    check_output("x0_issue", id_issue, 1'b1);
    tick();
    clear_cpl();
    no_instr();
    settle();
    check_grad("gc0", 1'b1, 5'd12, 64'hC0);
    check_output("gc0_no_exc", e_enter_gr, 1'b0);
    check_output("x0_funit_en", funit_en_e0, '0);
    check_output("x0_tag", tag_e0, 2'd0);
    tick();
    settle();
    check_output("exc_enter", e_enter_gr, 1'b1);
    check_output("exc_epc", n_epc_gr, 64'h2004);
    check_output("exc_cause", n_cause_gr, 3'b010);
    check_output("exc_redir_vld", redir_vld_xx, 1'b1);
    check_output("exc_redir_addr", redir_addr_xx, EXC_ADDR);
    check_output("exc_no_grad", grad_gr, 1'b0);
    tick();
    settle();
    check_output("exc_enter_once", e_enter_gr, 1'b0);

    // LSU replay at head
    apply_stimulus(1'b1, 64'h1040, 7'h20, 5'd13, 5'd31, 5'd31, 1'b0, 3'b000, 1'b0);
    settle();
    check_output("l0_issue", id_issue, 1'b1);
    tick();
    no_instr();
    complete(5, 2'd1, 64'h0, 1'b1, 1'b0, 1'b1, 64'h0);
    tick();
    clear_cpl();
    settle();
    check_output("rp_no_grad", grad_gr, 1'b0);
    check_output("rp_no_wen", rf_wen_gr, 1'b0);
    check_output("rp_redir_vld", redir_vld_xx, 1'b1);
    check_output("rp_redir_addr", redir_addr_xx, 64'h1040);
    tick();

    // Halt at head
    apply_stimulus(1'b1, 64'h1044, 7'h00, 5'd31, 5'd31, 5'd31, 1'b1, 3'b100, 1'b0);
    settle();
    check_output("h0_issue", id_issue, 1'b1);
    tick();
    no_instr();
    settle();
    check_output("halt_grad", grad_gr, 1'b1);
    check_output("halt_no_redir", redir_vld_xx, 1'b0);
    check_output("halt_no_enter", e_enter_gr, 1'b0);
    tick();
    apply_stimulus(1'b1, 64'h1048, 7'h01, 5'd14, 5'd31, 5'd31, 1'b0, 3'b000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      settle();
      check_output("halted_sticky", halted, 1'b1);
      check_output("halted_no_issue", id_issue, 1'b0);
      tick();
    end

    // Reset mid-operation clears halt and restarts fetch
    reset = 1'b1;
    settle();
    check_output("rst2_no_issue", id_issue, 1'b0);
    tick();
    settle();
    check_output("rst2_halted", halted, 1'b0);
    check_output("rst2_redir", redir_vld_xx, 1'b0);
    tick();
    reset = 1'b0;
    settle();
    check_output("rst2_post_redir", redir_vld_xx, 1'b1);
    check_output("rst2_post_addr", redir_addr_xx, RESET_ADDR);
    check_output("rst2_post_issue", id_issue, 1'b0);
    tick();
    settle();
    check_output("rst2_issue", id_issue, 1'b1);
    tick();
    no_instr();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
